// File: rtl/dotn_mac.sv
// dotn_mac: sequential fixed-point dot product with shift-add multiplier, chaining and final rounding/saturation
module dotn_mac #(
    parameter int W     = 16,
    parameter int FRAC  = 8,
    parameter int N     = 4,
    parameter int GUARD = 8,
    parameter int ROUND = 1,
    parameter int SAT   = 1
) (
    input  logic           clk_i,
    input  logic           reset_i,
    input  logic           start_i,
    input  logic           acc_en_i,
    input  logic [N*W-1:0] v1_i,
    input  logic [N*W-1:0] v2_i,
    output logic           busy_o,
    output logic           done_o,
    output logic [W-1:0]   result_o,
    output logic           overflow_o
);
    localparam int AW = 2 * W + GUARD;
    localparam int CW = W > 1 ? $clog2(W) : 1;
    localparam int KW = N > 1 ? $clog2(N) : 1;
    localparam logic [AW:0] RND = (ROUND != 0 && FRAC > 0) ? ((AW + 1)'(1) << FRAC) >> 1 : '0;
    localparam logic [W-1:0] MAXV = {1'b0, {(W - 1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MUL, ACC, FIN} state_t;

    state_t          state_q, state_d;
    logic [N*W-1:0]  v1_q, v1_d, v2_q, v2_d, v1_nxt, v2_nxt;
    logic [2*W-1:0]  mcand_q, mcand_d, prod_q, prod_d, term;
    logic [W-1:0]    mplier_q, mplier_d, la, lb, result_q, result_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [KW-1:0]   k_q, k_d;
    logic [AW-1:0]   acc_q, acc_d, sum;
    logic [AW:0]     rs, r;
    logic            ovf_q, ovf_d, done_q, done_d, in_rng;

    // Lane operands come from the inputs on acceptance, otherwise from the next lane of the latched vectors
    always_comb begin
        v1_nxt = v1_q >> W;
        v2_nxt = v2_q >> W;
        la     = (state_q == IDLE) ? v1_i[W-1:0] : v1_nxt[W-1:0];
        lb     = (state_q == IDLE) ? v2_i[W-1:0] : v2_nxt[W-1:0];
        term   = mplier_q[0] ? mcand_q : '0;
        sum    = acc_q + {{GUARD{prod_q[2*W-1]}}, prod_q};
        rs     = {acc_q[AW-1], acc_q} + RND;
        r      = $signed(rs) >>> FRAC;
        in_rng = (&r[AW:W-1]) | ~(|r[AW:W-1]);
    end

    // Next-state logic: the multiplier bit of weight -2^(W-1) is subtracted to keep the product exact
    always_comb begin
        state_d  = state_q;
        v1_d     = v1_q;
        v2_d     = v2_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        acc_d    = acc_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: if (start_i) begin
                v1_d     = v1_i;
                v2_d     = v2_i;
                acc_d    = acc_en_i ? acc_q : '0;
                mcand_d  = {{W{la[W-1]}}, la};
                mplier_d = lb;
                prod_d   = '0;
                cnt_d    = '0;
                k_d      = '0;
                state_d  = MUL;
            end
            MUL: begin
                prod_d   = (cnt_q == CW'(W - 1)) ? prod_q - term : prod_q + term;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                state_d  = (cnt_q == CW'(W - 1)) ? ACC : MUL;
            end
            ACC: begin
                acc_d    = sum;
                v1_d     = v1_nxt;
                v2_d     = v2_nxt;
                mcand_d  = {{W{la[W-1]}}, la};
                mplier_d = lb;
                prod_d   = '0;
                cnt_d    = '0;
                k_d      = k_q + KW'(1);
                state_d  = (k_q == KW'(N - 1)) ? FIN : MUL;
            end
            FIN: begin
                result_d = (in_rng || SAT == 0) ? r[W-1:0] : (r[AW] ? MINV : MAXV);
                ovf_d    = ~in_rng;
                done_d   = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset aborts any operation and clears the chained sum
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            v1_q     <= '0;
            v2_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            v1_q     <= v1_d;
            v2_q     <= v2_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            k_q      <= k_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            done_q   <= done_d;
        end
    end

    assign busy_o     = state_q != IDLE;
    assign done_o     = done_q;
    assign result_o   = result_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_dotn_mac.sv
// tb_dotn_mac: directed and random checks of dotn_mac against an arithmetic reference model
module tb_dotn_mac;
    localparam int W = 16, FRAC = 8, N = 4;
    localparam logic [63:0] B1 = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
    localparam logic [63:0] B2 = {4{16'h0100}};

    logic clk = 1'b0, reset = 1'b1, start = 1'b0, acc_en = 1'b0;
    logic [N*W-1:0] v1 = '0, v2 = '0;
    logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b, busy_c, done_c, ovf_c;
    logic [W-1:0] res_a, res_b, res_c;
    int n_chk = 0, n_fail = 0;
    longint s_mod = 0;

    always #5 clk = ~clk;

    dotn_mac #(.ROUND(1), .SAT(1)) u_main (.clk_i(clk), .reset_i(reset), .start_i(start), .acc_en_i(acc_en),
        .v1_i(v1), .v2_i(v2), .busy_o(busy_a), .done_o(done_a), .result_o(res_a), .overflow_o(ovf_a));
    dotn_mac #(.ROUND(1), .SAT(0)) u_wrap (.clk_i(clk), .reset_i(reset), .start_i(start), .acc_en_i(acc_en),
        .v1_i(v1), .v2_i(v2), .busy_o(busy_b), .done_o(done_b), .result_o(res_b), .overflow_o(ovf_b));
    dotn_mac #(.ROUND(0), .SAT(1)) u_flr (.clk_i(clk), .reset_i(reset), .start_i(start), .acc_en_i(acc_en),
        .v1_i(v1), .v2_i(v2), .busy_o(busy_c), .done_o(done_c), .result_o(res_c), .overflow_o(ovf_c));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint dot(input logic [63:0] a, input logic [63:0] b);
        longint acc = 0;
        for (int i = 0; i < N; i++) acc += longint'($signed(a[i*W +: W])) * longint'($signed(b[i*W +: W]));
        return acc;
    endfunction

    function automatic longint scaled(input longint s, input bit rnd);
        return (s + (rnd ? (longint'(1) << (FRAC - 1)) : 0)) >>> FRAC;
    endfunction

    function automatic logic [15:0] exp_res(input longint s, input bit rnd, input bit sat);
        longint r = scaled(s, rnd);
        if (sat && r > 32767) return 16'h7FFF;
        if (sat && r < -32768) return 16'h8000;
        return r[15:0];
    endfunction

    function automatic bit exp_ovf(input longint s, input bit rnd);
        longint r = scaled(s, rnd);
        return r > 32767 || r < -32768;
    endfunction

    task automatic launch(input logic [63:0] a, input logic [63:0] b, input bit en);
        @(negedge clk);
        v1 = a; v2 = b; acc_en = en; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s_mod = en ? s_mod + dot(a, b) : dot(a, b);
        s_mod = (s_mod <<< 24) >>> 24;
    endtask

    task automatic finish(input string tag, input bit disturb, input bit hold);
        int lat = 0;
        int bc = busy_a;
        for (int i = 1; i <= 300; i++) begin
            @(posedge clk); #1;
            if (disturb && i == 10) begin
                start = 1'b1; v1 = {$urandom, $urandom}; v2 = {$urandom, $urandom}; acc_en = ~acc_en;
            end
            if (disturb && i == 11) start = 1'b0;
            if (done_a) begin lat = i; break; end
            bc += busy_a;
        end
        if (hold) begin start = 1'b1; acc_en = 1'b1; end
        chk({tag, "_latency"}, lat, 69);
        chk({tag, "_busy_cycles"}, bc, 69);
        chk({tag, "_res_sat"}, res_a, exp_res(s_mod, 1, 1));
        chk({tag, "_ovf_sat"}, ovf_a, exp_ovf(s_mod, 1));
        chk({tag, "_res_wrap"}, res_b, exp_res(s_mod, 1, 0));
        chk({tag, "_ovf_wrap"}, ovf_b, exp_ovf(s_mod, 1));
        chk({tag, "_res_floor"}, res_c, exp_res(s_mod, 0, 1));
        chk({tag, "_ovf_floor"}, ovf_c, exp_ovf(s_mod, 0));
        if (!hold) begin
            @(posedge clk); #1;
            chk({tag, "_done_width"}, done_a, 0);
        end
    endtask

    initial begin
        int pulses;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_result", res_a, 0);
        chk("rst_overflow", ovf_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_done", done_a, 0);
        reset = 1'b0;
        launch(B1, B2, 0);
        finish("basic", 0, 0);
        chk("basic_const", res_a, 16'h0A00);
        launch(B1, B2, 1);
        finish("chain", 1, 0);
        chk("chain_const", res_a, 16'h1400);
        launch({32'h0, 16'h0080, 16'hFE80}, {32'h0, 16'hFFC0, 16'h0200}, 0);
        finish("signed", 0, 0);
        chk("signed_const", res_a, 16'hFCE0);
        launch({4{16'h7FFF}}, {4{16'h7FFF}}, 0);
        finish("ovf_max", 0, 0);
        chk("ovf_sat_const", res_a, 16'h7FFF);
        chk("ovf_wrap_const", res_b, 16'hFC00);
        launch({48'h0, 16'h8000}, {48'h0, 16'h8000}, 0);
        finish("ovf_min", 0, 0);
        chk("ovf_min_const", res_a, 16'h7FFF);
        launch({48'h0, 16'h0001}, {48'h0, 16'h0080}, 0);
        finish("rnd_pos", 0, 0);
        chk("rnd_pos_up", res_a, 16'h0001);
        chk("rnd_pos_floor", res_c, 16'h0000);
        launch({48'h0, 16'hFFFF}, {48'h0, 16'h0080}, 0);
        finish("rnd_neg", 0, 0);
        chk("rnd_neg_up", res_a, 16'h0000);
        chk("rnd_neg_floor", res_c, 16'hFFFF);
        launch(B1, B2, 0);
        finish("b2b_first", 0, 1);
        @(posedge clk); #1;
        start = 1'b0;
        s_mod = s_mod + dot(B1, B2);
        finish("b2b_second", 0, 0);
        chk("b2b_const", res_a, 16'h1400);
        for (int t = 0; t < 8; t++) begin
            launch({$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
            finish("random", t[0], 0);
        end
        launch(B1, B2, 1);
        repeat (29) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrst_result", res_a, 0);
        chk("midrst_overflow", ovf_a, 0);
        chk("midrst_busy", busy_a, 0);
        chk("midrst_done", done_a, 0);
        reset = 1'b0;
        s_mod = 0;
        pulses = 0;
        repeat (80) begin
            @(posedge clk); #1;
            pulses += done_a;
        end
        chk("midrst_no_done", pulses, 0);
        launch(B1, B2, 1);
        finish("after_rst", 0, 0);
        chk("after_rst_const", res_a, 16'h0A00);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
